// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - bus bundle between the IF/MEM stages, the arbiter and the backing memory
//
// Purpose: groups every handshake/data signal of mem_port_arbiter so the arbiter,
//          the pipeline and the memory model share one connection object.
// Signals:
//   if_req/if_addr            fetch request from IF stage (held until if_done)
//   if_rdata/if_done/if_stall fetch response and stall back to IF stage
//   dm_req/dm_we/dm_addr/dm_wdata  load/store request from MEM stage (held until dm_done)
//   dm_rdata/dm_done/dm_stall load data, completion and stall back to MEM stage
//   mem_req/mem_we/mem_addr/mem_wdata  request toward the backing memory
//   mem_rdata/mem_ack         backing-memory response
//   busy                      arbiter FSM not idle
// Modports:
//   slave  - the arbiter side
//   master - the surrounding pipeline + memory side
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [31:0]       if_rdata;
  logic              if_done;
  logic              if_stall;

  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_done;
  logic              dm_stall;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  logic              busy;

  modport slave (
    input  if_req, if_addr,
    output if_rdata, if_done, if_stall,
    input  dm_req, dm_we, dm_addr, dm_wdata,
    output dm_rdata, dm_done, dm_stall,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack,
    output busy
  );

  modport master (
    output if_req, if_addr,
    input  if_rdata, if_done, if_stall,
    output dm_req, dm_we, dm_addr, dm_wdata,
    input  dm_rdata, dm_done, dm_stall,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack,
    input  busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one variable-latency memory port between IF fetch and MEM load/store
//
// Purpose: arbitrates the single backing-memory port between the fetch stage and the
//          data stage, runs each access through a req/ack handshake and returns the data
//          to the stage that owned the access. DM (older instruction) normally wins ties.
// Ports:
//   clock  in  rising-edge clock
//   reset  in  asynchronous, active-high
//   bus    slave modport of mem_port_arbiter_if (IF, DM and memory signals, busy)
// Optional feature:
//   ARB_STARVE_GUARD_EN - when defined, a 3-bit saturating counter of DM grants taken while
//   IF was waiting lets IF win a tie once it reaches STARVE_LIMIT. Undefined: strict DM priority.
// FSM: IDLE -> GNT_DM | GNT_IF -> RESP -> IDLE
module mem_port_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
`ifdef ARB_STARVE_GUARD_EN
  , parameter int STARVE_LIMIT = 4
`endif
) (
  input  logic                 clock,
  input  logic                 reset,
  mem_port_arbiter_if.slave    bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GNT_DM = 2'd1,
    ST_GNT_IF = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Access context captured on the grant edge; requester inputs are not looked at again
  // until the next grant, so mid-access changes on the stage side have no effect.
  logic [ADDR_W-1:0] lat_addr_q;
  logic              lat_we_q;
  logic [DATA_W-1:0] lat_wdata_q;
  logic              lat_owner_if_q;

  logic [31:0]       if_rdata_q;
  logic [DATA_W-1:0] dm_rdata_q;

  logic grant_dm;
  logic grant_if;
  logic in_gnt;

  assign in_gnt = (state_q == ST_GNT_DM) || (state_q == ST_GNT_IF);

  // ---------------------------------------------------------------------------
  // Arbitration decision (only acted upon in IDLE)
  // ---------------------------------------------------------------------------
`ifdef ARB_STARVE_GUARD_EN
  logic [2:0] starve_cnt_q;
  logic       starve_hit;

  assign starve_hit = (32'(starve_cnt_q) >= STARVE_LIMIT);

  always_comb begin
    grant_if = bus.if_req & (~bus.dm_req | starve_hit);
    grant_dm = bus.dm_req & ~grant_if;
  end

  // Counts DM grants that made a waiting fetch wait longer; saturates rather than wrapping
  // so a long DM burst cannot accidentally reset IF's claim.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      starve_cnt_q <= 3'd0;
    end else if (state_q == ST_IDLE) begin
      if (grant_if) begin
        starve_cnt_q <= 3'd0;
      end else if (grant_dm && bus.if_req && (starve_cnt_q != 3'd7)) begin
        starve_cnt_q <= starve_cnt_q + 3'd1;
      end
    end
  end
`else
  always_comb begin
    grant_dm = bus.dm_req;
    grant_if = bus.if_req & ~bus.dm_req;
  end
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_dm) begin
          state_d = ST_GNT_DM;
        end else if (grant_if) begin
          state_d = ST_GNT_IF;
        end
      end
      ST_GNT_DM, ST_GNT_IF: begin
        if (bus.mem_ack) begin
          state_d = ST_RESP;
        end
      end
      // RESP never arbitrates: the stage sees done this cycle and may drop its request
      // before the next IDLE evaluation.
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs. mem_req is decoded from the state register, so an asynchronous
  // reset drops it in the same cycle without waiting for a clock edge.
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.mem_req   = in_gnt;
    bus.mem_we    = in_gnt & lat_we_q;
    bus.mem_addr  = {lat_addr_q[ADDR_W-1:3], 3'b000};
    bus.mem_wdata = lat_wdata_q;
    bus.if_done   = (state_q == ST_RESP) &  lat_owner_if_q;
    bus.dm_done   = (state_q == ST_RESP) & ~lat_owner_if_q;
    bus.busy      = (state_q != ST_IDLE);
    bus.if_rdata  = if_rdata_q;
    bus.dm_rdata  = dm_rdata_q;
    bus.if_stall  = bus.if_req & ~bus.if_done;
    bus.dm_stall  = bus.dm_req & ~bus.dm_done;
  end

  // ---------------------------------------------------------------------------
  // Grant-edge capture of the winning request
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lat_addr_q     <= '0;
      lat_we_q       <= 1'b0;
      lat_wdata_q    <= '0;
      lat_owner_if_q <= 1'b0;
    end else if (state_q == ST_IDLE) begin
      if (grant_dm) begin
        lat_addr_q     <= bus.dm_addr;
        lat_we_q       <= bus.dm_we;
        lat_wdata_q    <= bus.dm_wdata;
        lat_owner_if_q <= 1'b0;
      end else if (grant_if) begin
        lat_addr_q     <= bus.if_addr;
        lat_we_q       <= 1'b0;
        lat_wdata_q    <= '0;
        lat_owner_if_q <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read-data capture in the ack cycle. Each owner's register keeps its value until
  // that owner's next completed read; stores leave dm_rdata untouched.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else if (bus.mem_ack) begin
      if (state_q == ST_GNT_IF) begin
        // Instructions are 32 bits; address bit 2 picks the half of the doubleword.
        if_rdata_q <= lat_addr_q[2] ? bus.mem_rdata[DATA_W-1 -: 32] : bus.mem_rdata[31:0];
      end else if ((state_q == ST_GNT_DM) && !lat_we_q) begin
        dm_rdata_q <= bus.mem_rdata;
      end
    end
  end

  // Byte-offset bits below the half-word select carry no meaning for a doubleword port.
  logic unused_addr_bits;
  assign unused_addr_bits = ^lat_addr_q[1:0];

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard testbench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  mem_port_arbiter_if #(.ADDR_W(64), .DATA_W(64)) bus ();

  mem_port_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [63:0] addr;
    logic        we;
    logic [63:0] wdata;
  } mem_exp_t;

  typedef struct {
    bit          is_if;
    logic [63:0] data;
  } done_exp_t;

  mem_exp_t  exp_mem[$];
  done_exp_t exp_done[$];
  mem_exp_t  me;
  done_exp_t de;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [63:0] mem_model [logic [63:0]];

  // responder controls
  bit          auto_ack = 1'b1;
  int          ack_lat = 1;
  bit          double_ack = 1'b0;
  bit          man_ack = 1'b0;
  logic [63:0] man_data = '0;
  bit          second_pending = 1'b0;
  int          wait_cnt = 0;

  int last_rise_cyc = 0;
  int last_dm_done_cyc = 0;
  logic prev_mem_req = 1'b0;

  always @(posedge clock) cyc = cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic push_mem(input logic [63:0] a, input logic we, input logic [63:0] wd);
    mem_exp_t e;
    e.addr = a; e.we = we; e.wdata = wd;
    exp_mem.push_back(e);
  endtask

  task automatic push_done(input bit is_if, input logic [63:0] d);
    done_exp_t e;
    e.is_if = is_if; e.data = d;
    exp_done.push_back(e);
  endtask

  // Memory responder: acts 2 time units after each rising edge.
  initial begin
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clock);
      #2;
      if (second_pending) begin
        bus.mem_ack    = 1'b1;
        bus.mem_rdata  = 64'hDEADBEEF_DEADBEEF;
        second_pending = 1'b0;
      end else if (man_ack) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = man_data;
      end else if (auto_ack && bus.mem_req) begin
        wait_cnt++;
        if (wait_cnt >= ack_lat) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = mem_model.exists(bus.mem_addr) ? mem_model[bus.mem_addr] : 64'h0;
          if (bus.mem_we) mem_model[bus.mem_addr] = bus.mem_wdata;
          wait_cnt       = 0;
          second_pending = double_ack;
        end else begin
          bus.mem_ack = 1'b0;
        end
      end else begin
        bus.mem_ack = 1'b0;
        wait_cnt    = 0;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT starts a memory request or pulses done.
  always @(negedge clock) begin
    if (bus.mem_req && !prev_mem_req) begin
      last_rise_cyc = cyc;
      if (exp_mem.size() == 0) begin
        checks++; errors++;
        $display("FAIL mem_req_unexpected actual addr=%h required=no request", bus.mem_addr);
      end else begin
        me = exp_mem.pop_front();
        check("mem_addr", bus.mem_addr, me.addr);
        check("mem_we", {63'd0, bus.mem_we}, {63'd0, me.we});
        if (me.we) check("mem_wdata", bus.mem_wdata, me.wdata);
      end
    end
    prev_mem_req = bus.mem_req;
    if (bus.if_done || bus.dm_done) begin
      if (bus.dm_done) last_dm_done_cyc = cyc;
      if (exp_done.size() == 0) begin
        checks++; errors++;
        $display("FAIL done_unexpected actual if_done=%b dm_done=%b required=none", bus.if_done, bus.dm_done);
      end else begin
        de = exp_done.pop_front();
        check("done_owner_if", {63'd0, bus.if_done}, {63'd0, de.is_if});
        check("done_owner_dm", {63'd0, bus.dm_done}, {63'd0, !de.is_if});
        if (de.is_if) check("if_rdata", {32'd0, bus.if_rdata}, de.data);
        else          check("dm_rdata", bus.dm_rdata, de.data);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_done(input int budget, output bit got_if);
    got_if = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clock);
      if (bus.if_done || bus.dm_done) begin
        got_if = bus.if_done;
        return;
      end
    end
    checks++; errors++;
    $display("FAIL wait_done_timeout actual=no done required=done within %0d cycles", budget);
  endtask

  bit g;
  int req_cyc;
  int done_cyc;
  bit stall_ok;
  bit if_seen;

  initial begin
    bus.if_req = 0; bus.if_addr = '0;
    bus.dm_req = 0; bus.dm_we = 0; bus.dm_addr = '0; bus.dm_wdata = '0;
    mem_model[64'h100] = 64'hAABBCCDD_11223344;
    mem_model[64'h208] = 64'h01234567_89ABCDEF;
    mem_model[64'h300] = 64'h33333333_33333333;
    mem_model[64'h400] = 64'h44444444_12345678;
    mem_model[64'h500] = 64'h50505050_50505050;
    mem_model[64'h600] = 64'h66666666_77777777;

    // Reset values
    repeat (2) tick();
    check("rst_mem_req", {63'd0, bus.mem_req}, 64'd0);
    check("rst_busy", {63'd0, bus.busy}, 64'd0);
    check("rst_mem_addr", bus.mem_addr, 64'd0);
    check("rst_dones", {62'd0, bus.if_done, bus.dm_done}, 64'd0);
    check("rst_rdata", {bus.if_rdata, bus.dm_rdata[31:0]}, 64'd0);
    @(negedge clock);
    reset = 1'b0;

    // Reset in the middle of a DM grant
    ack_lat = 5;
    push_mem(64'h40, 1'b0, 64'h0);
    tick();
    bus.dm_req = 1; bus.dm_addr = 64'h40;
    @(negedge clock);
    @(negedge clock);
    check("pre_rst_mem_req", {63'd0, bus.mem_req}, 64'd1);
    reset = 1'b1;
    bus.dm_req = 0;
    #1;
    check("midrst_mem_req", {63'd0, bus.mem_req}, 64'd0);
    check("midrst_busy", {63'd0, bus.busy}, 64'd0);
    check("midrst_dm_done", {63'd0, bus.dm_done}, 64'd0);
    @(negedge clock);
    reset = 1'b0;
    auto_ack = 0;
    tick();
    man_ack = 1; man_data = 64'h12121212_34343434;
    tick();
    man_ack = 0;
    repeat (3) tick();
    check("late_ack_busy", {63'd0, bus.busy}, 64'd0);
    check("late_ack_dm_rdata", bus.dm_rdata, 64'd0);
    auto_ack = 1;

    // Fetch at 0x104, ack in the third request cycle
    ack_lat = 3;
    push_mem(64'h100, 1'b0, 64'h0);
    push_done(1'b1, 64'hAABBCCDD);
    tick();
    bus.if_req = 1; bus.if_addr = 64'h104;
    req_cyc = cyc;
    wait_done(20, g);
    done_cyc = cyc;
    check("fetch_if_stall_in_done", {63'd0, bus.if_stall}, 64'd0);
    check("fetch_req_latency", 64'(last_rise_cyc - req_cyc), 64'd1);
    check("fetch_done_latency", 64'(done_cyc - req_cyc), 64'd4);
    bus.if_req = 0;

    // Store 0x1F to 0xF8
    ack_lat = 1;
    push_mem(64'hF8, 1'b1, 64'h1F);
    push_done(1'b0, 64'h0);
    tick();
    bus.dm_req = 1; bus.dm_we = 1; bus.dm_addr = 64'hF8; bus.dm_wdata = 64'h1F;
    wait_done(20, g);
    bus.dm_req = 0; bus.dm_we = 0;

    // Load 0xF8, with the address changed while the access is in flight
    ack_lat = 3;
    push_mem(64'hF8, 1'b0, 64'h0);
    push_done(1'b0, 64'h1F);
    tick();
    bus.dm_req = 1; bus.dm_addr = 64'hF8;
    tick();
    bus.dm_addr = 64'h998; bus.dm_wdata = 64'hFFFF;
    @(negedge clock);
    check("midaccess_mem_addr", bus.mem_addr, 64'hF8);
    wait_done(20, g);
    bus.dm_req = 0;

    // Spurious ack in IDLE
    auto_ack = 0;
    tick();
    man_ack = 1; man_data = 64'h55555555_55555555;
    tick();
    man_ack = 0;
    repeat (2) tick();
    check("idle_ack_dm_rdata", bus.dm_rdata, 64'h1F);
    check("idle_ack_if_rdata", {32'd0, bus.if_rdata}, 64'hAABBCCDD);
    check("idle_ack_busy", {63'd0, bus.busy}, 64'd0);
    auto_ack = 1;

    // Load at unaligned 0x20D with a repeated ack landing in RESP
    ack_lat = 1; double_ack = 1;
    push_mem(64'h208, 1'b0, 64'h0);
    push_done(1'b0, 64'h01234567_89ABCDEF);
    tick();
    bus.dm_req = 1; bus.dm_addr = 64'h20D;
    wait_done(20, g);
    bus.dm_req = 0;
    repeat (3) tick();
    double_ack = 0;
    check("resp_ack_dm_rdata", bus.dm_rdata, 64'h01234567_89ABCDEF);
    check("resp_ack_busy", {63'd0, bus.busy}, 64'd0);

    // Contention: both raised together, DM first, IF granted k+2
    ack_lat = 2;
    push_mem(64'h300, 1'b0, 64'h0);
    push_mem(64'h400, 1'b0, 64'h0);
    push_done(1'b0, 64'h33333333_33333333);
    push_done(1'b1, 64'h12345678);
    tick();
    bus.if_req = 1; bus.if_addr = 64'h400;
    bus.dm_req = 1; bus.dm_addr = 64'h300;
    stall_ok = 1; if_seen = 0;
    for (int n = 0; n < 30 && !if_seen; n++) begin
      @(negedge clock);
      if (bus.if_done) if_seen = 1;
      else begin
        if (!bus.if_stall) stall_ok = 0;
        if (bus.dm_done) bus.dm_req = 0;
      end
    end
    check("contention_if_done_seen", {63'd0, if_seen}, 64'd1);
    check("contention_if_stall_high", {63'd0, stall_ok}, 64'd1);
    check("contention_if_grant_gap", 64'(last_rise_cyc - last_dm_done_cyc), 64'd2);
    bus.if_req = 0;
    bus.dm_req = 0;
    tick();

    // Continuous DM with IF waiting
    ack_lat = 1;
`ifdef ARB_STARVE_GUARD_EN
    for (int n = 0; n < 4; n++) begin
      push_mem(64'h500, 1'b0, 64'h0);
      push_done(1'b0, 64'h50505050_50505050);
    end
    push_mem(64'h600, 1'b0, 64'h0);
    push_done(1'b1, 64'h66666666);
    push_mem(64'h500, 1'b0, 64'h0);
    push_done(1'b0, 64'h50505050_50505050);
`else
    for (int n = 0; n < 6; n++) begin
      push_mem(64'h500, 1'b0, 64'h0);
      push_done(1'b0, 64'h50505050_50505050);
    end
    push_mem(64'h600, 1'b0, 64'h0);
    push_done(1'b1, 64'h66666666);
`endif
    tick();
    bus.dm_req = 1; bus.dm_addr = 64'h500;
    bus.if_req = 1; bus.if_addr = 64'h604;
    for (int n = 0; n < 6; n++) begin
      wait_done(20, g);
      if (g) bus.if_req = 0;
    end
    bus.dm_req = 0;
`ifndef ARB_STARVE_GUARD_EN
    wait_done(20, g);
    check("starve_final_is_if", {63'd0, g}, 64'd1);
    bus.if_req = 0;
`endif
    repeat (3) tick();
    check("exp_mem_drained", 64'(exp_mem.size()), 64'd0);
    check("exp_done_drained", 64'(exp_done.size()), 64'd0);
    check("end_busy", {63'd0, bus.busy}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
